// File: rtl/alarm_zone_if.sv
// ---------------------------------------------------------------------------
// alarm_zone_if
// Bundles the keypad status, sensor/bypass inputs and the status/siren
// outputs of the alarm zone controller.
//   master : drives KEY_STATUS, SENSOR_IN, ZONE_BYPASS (and TAMPER_IN);
//            observes SIREN_OUT, STATE, ARMED_OUT, ZONE_LATCH
//   slave  : the controller side (mirror of master)
// Optional macro TAMPER_EN adds the TAMPER_IN signal.
// ---------------------------------------------------------------------------
interface alarm_zone_if #(
   parameter int N_ZONES = 4
);
   logic [1:0]         KEY_STATUS;
   logic [N_ZONES-1:0] SENSOR_IN;
   logic [N_ZONES-1:0] ZONE_BYPASS;
`ifdef TAMPER_EN
   logic               TAMPER_IN;
`endif
   logic               SIREN_OUT;
   logic [2:0]         STATE;
   logic               ARMED_OUT;
   logic [N_ZONES-1:0] ZONE_LATCH;

`ifdef TAMPER_EN
   modport master (output KEY_STATUS, SENSOR_IN, ZONE_BYPASS, TAMPER_IN,
                   input  SIREN_OUT, STATE, ARMED_OUT, ZONE_LATCH);
   modport slave  (input  KEY_STATUS, SENSOR_IN, ZONE_BYPASS, TAMPER_IN,
                   output SIREN_OUT, STATE, ARMED_OUT, ZONE_LATCH);
`else
   modport master (output KEY_STATUS, SENSOR_IN, ZONE_BYPASS,
                   input  SIREN_OUT, STATE, ARMED_OUT, ZONE_LATCH);
   modport slave  (input  KEY_STATUS, SENSOR_IN, ZONE_BYPASS,
                   output SIREN_OUT, STATE, ARMED_OUT, ZONE_LATCH);
`endif
endinterface

// File: rtl/alarm_zone_controller.sv
// ---------------------------------------------------------------------------
// alarm_zone_controller
// Main alarm FSM: N sensor zones (instant or delayed), exit delay, entry
// delay, siren timeout and keypad error lockout.
// Ports:
//   SERCLK_OUT  in   clock
//   RESET_IN    in   asynchronous, active-high reset
//   bus         alarm_zone_if.slave
//      KEY_STATUS  in   0=OK, 2=ERROR, 3=NO_KEY (1 treated as NO_KEY)
//      SENSOR_IN   in   raw zone inputs, asynchronous, active-high
//      ZONE_BYPASS in   zones ignored, captured when arming
//      TAMPER_IN   in   only with TAMPER_EN: forces ALARM, blocks OK
//      SIREN_OUT   out  registered, high only in ALARM
//      STATE       out  0 DISARMED,1 EXIT_DELAY,2 ARMED,3 ENTRY_DELAY,
//                       4 ALARM,5 SILENCED
//      ARMED_OUT   out  registered, high in every state except DISARMED
//      ZONE_LATCH  out  zones tripped since last arming
// Optional feature macro: TAMPER_EN
// ---------------------------------------------------------------------------
module alarm_zone_controller #(
   parameter int                 N_ZONES       = 4,
   parameter logic [N_ZONES-1:0] DELAYED_ZONES = N_ZONES'(4'b0010),
   parameter int                 EXIT_TICKS    = 50000,
   parameter int                 ENTRY_TICKS   = 50000,
   parameter int                 SIREN_TICKS   = 300000,
   parameter int                 CNT_W         = 20,
   parameter int                 MAX_KEY_ERR   = 3
) (
   input  logic        SERCLK_OUT,
   input  logic        RESET_IN,
   alarm_zone_if.slave bus
);

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_EXIT     = 3'd1,
      ST_ARMED    = 3'd2,
      ST_ENTRY    = 3'd3,
      ST_ALARM    = 3'd4,
      ST_SILENCED = 3'd5
   } state_t;

   localparam logic [1:0] KEY_OK   = 2'b00;
   localparam logic [1:0] KEY_ERR  = 2'b10;
   localparam logic [1:0] KEY_NONE = 2'b11;

   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   timer_q,    timer_d;
   logic [2:0]         err_cnt_q,  err_cnt_d;
   logic [N_ZONES-1:0] bypass_q,   bypass_d;
   logic [N_ZONES-1:0] latch_q,    latch_d;
   logic [N_ZONES-1:0] sync1_q,    sync1_d;
   logic [N_ZONES-1:0] sync2_q,    sync2_d;
   logic [1:0]         key_prev_q, key_prev_d;
   logic               first_q,    first_d;
   logic               siren_q,    siren_d;
   logic               armed_q,    armed_d;
`ifdef TAMPER_EN
   logic               tamp1_q,    tamp1_d;
   logic               tamp2_q,    tamp2_d;
`endif

   logic [1:0]         key_cur_s;
   logic               tamper_s;
   logic               ok_ev_s;
   logic               err_ev_s;
   logic               lockout_s;
   logic               expired_s;
   logic [2:0]         err_next_s;
   logic [N_ZONES-1:0] active_s;
   logic [N_ZONES-1:0] instant_s;
   logic [N_ZONES-1:0] delayed_s;

   // Reload value of the state timer for the state being entered.
   function automatic logic [CNT_W-1:0] load_value(input state_t st);
      case (st)
         ST_EXIT:  load_value = CNT_W'(EXIT_TICKS - 1);
         ST_ENTRY: load_value = CNT_W'(ENTRY_TICKS - 1);
         ST_ALARM: load_value = CNT_W'(SIREN_TICKS - 1);
         default:  load_value = {CNT_W{1'b0}};
      endcase
   endfunction

   // Key edge detection, zone qualification and next-state decision.
   always_comb begin
      key_cur_s  = (bus.KEY_STATUS == 2'b01) ? KEY_NONE : bus.KEY_STATUS;
`ifdef TAMPER_EN
      tamper_s   = tamp2_q;
      tamp1_d    = bus.TAMPER_IN;
      tamp2_d    = tamp1_q;
`else
      tamper_s   = 1'b0;
`endif
      // A tamper condition masks OK so an active tamper cannot be disarmed.
      ok_ev_s    = ~first_q & (key_cur_s == KEY_OK) & (key_prev_q != KEY_OK) & ~tamper_s;
      err_ev_s   = ~first_q & (key_cur_s == KEY_ERR) & (key_prev_q != KEY_ERR);
      err_next_s = err_cnt_q + 3'd1;
      lockout_s  = err_ev_s & ((state_q == ST_ARMED) | (state_q == ST_ENTRY)) &
                   (err_next_s == 3'(MAX_KEY_ERR));
      expired_s  = (timer_q == {CNT_W{1'b0}});
      active_s   = sync2_q & ~bypass_q;
      instant_s  = active_s & ~DELAYED_ZONES;
      delayed_s  = active_s & DELAYED_ZONES;

      sync1_d    = bus.SENSOR_IN;
      sync2_d    = sync1_q;
      key_prev_d = key_cur_s;
      first_d    = 1'b0;
      state_d    = state_q;
      bypass_d   = bypass_q;

      if (state_q inside {ST_ARMED, ST_ENTRY, ST_ALARM, ST_SILENCED}) begin
         latch_d = latch_q | active_s;
      end else begin
         latch_d = latch_q;
      end

      if (ok_ev_s) begin
         err_cnt_d = 3'd0;
      end else if (err_ev_s && ((state_q == ST_ARMED) || (state_q == ST_ENTRY))) begin
         err_cnt_d = lockout_s ? 3'd0 : err_next_s;
      end else begin
         err_cnt_d = err_cnt_q;
      end

      // Priority: OK > tamper > instant zone > lockout > expiry > delayed zone.
      if (ok_ev_s) begin
         if (state_q == ST_DISARMED) begin
            state_d  = ST_EXIT;
            bypass_d = bus.ZONE_BYPASS;
            latch_d  = {N_ZONES{1'b0}};
         end else begin
            state_d  = ST_DISARMED;
         end
      end else if (tamper_s) begin
         state_d = ST_ALARM;
      end else begin
         case (state_q)
            ST_DISARMED: state_d = ST_DISARMED;
            ST_EXIT:     state_d = expired_s ? ST_ARMED : ST_EXIT;
            ST_ARMED: begin
               if (|instant_s)      state_d = ST_ALARM;
               else if (lockout_s)  state_d = ST_ALARM;
               else if (|delayed_s) state_d = ST_ENTRY;
               else                 state_d = ST_ARMED;
            end
            ST_ENTRY: begin
               if (|instant_s)      state_d = ST_ALARM;
               else if (lockout_s)  state_d = ST_ALARM;
               else if (expired_s)  state_d = ST_ALARM;
               else                 state_d = ST_ENTRY;
            end
            ST_ALARM:    state_d = expired_s ? ST_SILENCED : ST_ALARM;
            // Only a zone that has not yet tripped this arming re-sounds the siren.
            ST_SILENCED: state_d = (|(active_s & ~latch_q)) ? ST_ALARM : ST_SILENCED;
            default:     state_d = ST_DISARMED;
         endcase
      end

      // Any state change reloads the timer, so SILENCED->ALARM restarts the siren period.
      if (state_d != state_q) begin
         timer_d = load_value(state_d);
      end else if (!expired_s) begin
         timer_d = timer_q - CNT_W'(1);
      end else begin
         timer_d = timer_q;
      end

      siren_d = (state_d == ST_ALARM);
      armed_d = (state_d != ST_DISARMED);
   end

   // State, timer, latches and output registers with asynchronous reset.
   always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
      if (RESET_IN) begin
         state_q    <= ST_DISARMED;
         timer_q    <= {CNT_W{1'b0}};
         err_cnt_q  <= 3'd0;
         bypass_q   <= {N_ZONES{1'b0}};
         latch_q    <= {N_ZONES{1'b0}};
         sync1_q    <= {N_ZONES{1'b0}};
         sync2_q    <= {N_ZONES{1'b0}};
         key_prev_q <= KEY_NONE;
         first_q    <= 1'b1;
         siren_q    <= 1'b0;
         armed_q    <= 1'b0;
`ifdef TAMPER_EN
         tamp1_q    <= 1'b0;
         tamp2_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         err_cnt_q  <= err_cnt_d;
         bypass_q   <= bypass_d;
         latch_q    <= latch_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         key_prev_q <= key_prev_d;
         first_q    <= first_d;
         siren_q    <= siren_d;
         armed_q    <= armed_d;
`ifdef TAMPER_EN
         tamp1_q    <= tamp1_d;
         tamp2_q    <= tamp2_d;
`endif
      end
   end

   assign bus.STATE      = state_q;
   assign bus.SIREN_OUT  = siren_q;
   assign bus.ARMED_OUT  = armed_q;
   assign bus.ZONE_LATCH = latch_q;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_zone_controller
// Directed scenarios followed by randomized keypad/sensor/bypass traffic with
// occasional asynchronous resets. A behavioural model (state code plus
// cycles-spent-in-state) predicts every output and is compared each cycle.
// ---------------------------------------------------------------------------
module tb_alarm_zone_controller;
   localparam int         NZ    = 4;
   localparam logic [3:0] DLY   = 4'b0010;
   localparam int         EXIT  = 8;
   localparam int         ENTRY = 6;
   localparam int         SIREN = 10;
   localparam int         MAXE  = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alarm_zone_if #(.N_ZONES(NZ)) bus_if ();

   alarm_zone_controller #(
      .N_ZONES(NZ), .DELAYED_ZONES(DLY), .EXIT_TICKS(EXIT), .ENTRY_TICKS(ENTRY),
      .SIREN_TICKS(SIREN), .CNT_W(20), .MAX_KEY_ERR(MAXE)
   ) dut (
      .SERCLK_OUT(clk),
      .RESET_IN(rst),
      .bus(bus_if)
   );

`ifdef TAMPER_EN
   initial bus_if.TAMPER_IN = 1'b0;
`endif

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int         m_state, m_elapsed, m_errs;
   logic [3:0] m_latch, m_mask, m_s1, m_s2;
   logic [1:0] m_prev;
   bit         m_first;

   task automatic model_reset();
      m_state = 0; m_elapsed = 0; m_errs = 0;
      m_latch = 4'd0; m_mask = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0;
      m_prev = 2'd3; m_first = 1'b1;
   endtask

   task automatic model_step();
      logic [1:0] k;
      logic [3:0] act, inst, dly;
      bit ok, er, lock, expd;
      int dur, nxt;
      k    = (bus_if.KEY_STATUS == 2'd1) ? 2'd3 : bus_if.KEY_STATUS;
      ok   = !m_first && (k == 2'd0) && (m_prev != 2'd0);
      er   = !m_first && (k == 2'd2) && (m_prev != 2'd2);
      act  = m_s2 & ~m_mask;
      inst = act & ~DLY;
      dly  = act & DLY;
      case (m_state)
         1:       dur = EXIT;
         3:       dur = ENTRY;
         4:       dur = SIREN;
         default: dur = 0;
      endcase
      expd = (dur > 0) && (m_elapsed + 1 >= dur);
      lock = er && (m_state == 2 || m_state == 3) && (m_errs + 1 >= MAXE);
      nxt  = m_state;
      if (ok)                         nxt = (m_state == 0) ? 1 : 0;
      else if (m_state == 0)          nxt = 0;
      else if (m_state == 1)          nxt = expd ? 2 : 1;
      else if (m_state == 4)          nxt = expd ? 5 : 4;
      else if (m_state == 5)          nxt = ((act & ~m_latch) != 4'd0) ? 4 : 5;
      else if (inst != 4'd0)          nxt = 4;
      else if (lock)                  nxt = 4;
      else if (m_state == 3 && expd)  nxt = 4;
      else if (m_state == 2 && dly != 4'd0) nxt = 3;
      if (m_state >= 2) m_latch = m_latch | act;
      if (ok && m_state == 0) begin
         m_mask  = bus_if.ZONE_BYPASS;
         m_latch = 4'd0;
      end
      if (ok) m_errs = 0;
      else if (er && (m_state == 2 || m_state == 3)) m_errs = lock ? 0 : m_errs + 1;
      m_elapsed = (nxt == m_state) ? m_elapsed + 1 : 0;
      m_state   = nxt;
      m_prev    = k;
      m_first   = 1'b0;
      m_s2      = m_s1;
      m_s1      = bus_if.SENSOR_IN;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("model_state", 8'(bus_if.STATE),      8'(m_state));
         chk("model_siren", 8'(bus_if.SIREN_OUT),  8'(m_state == 4));
         chk("model_armed", 8'(bus_if.ARMED_OUT),  8'(m_state != 0));
         chk("model_latch", 8'(bus_if.ZONE_LATCH), 8'(m_latch));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [1:0] code);
      bus_if.KEY_STATUS = code;
      cyc(1);
      bus_if.KEY_STATUS = 2'd3;
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("async_siren", 8'(bus_if.SIREN_OUT), 8'd0);
      chk("async_state", 8'(bus_if.STATE),     8'd0);
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      int hold;
      int r;
      bus_if.KEY_STATUS  = 2'd3;
      bus_if.SENSOR_IN   = 4'd0;
      bus_if.ZONE_BYPASS = 4'd0;
      rst = 1'b0;
      #1 rst = 1'b1;
      cyc(3);
      chk("rst_state", 8'(bus_if.STATE),      8'd0);
      chk("rst_siren", 8'(bus_if.SIREN_OUT),  8'd0);
      chk("rst_armed", 8'(bus_if.ARMED_OUT),  8'd0);
      chk("rst_latch", 8'(bus_if.ZONE_LATCH), 8'd0);
      rst = 1'b0;
      cyc(2);

      // Arm: exit delay lasts 8 cycles, sensor activity ignored meanwhile.
      press(2'd0);
      chk("exit_first", 8'(bus_if.STATE), 8'd1);
      chk("exit_armed_out", 8'(bus_if.ARMED_OUT), 8'd1);
      bus_if.SENSOR_IN = 4'b0001;
      cyc(2);
      bus_if.SENSOR_IN = 4'b0000;
      cyc(5);
      chk("exit_last", 8'(bus_if.STATE), 8'd1);
      cyc(1);
      chk("armed", 8'(bus_if.STATE), 8'd2);
      chk("armed_latch", 8'(bus_if.ZONE_LATCH), 8'd0);

      // Delayed zone: entry delay of 6 cycles, then ALARM.
      bus_if.SENSOR_IN = 4'b0010;
      cyc(3);
      chk("entry_first", 8'(bus_if.STATE), 8'd3);
      bus_if.SENSOR_IN = 4'b0000;
      cyc(5);
      chk("entry_last", 8'(bus_if.STATE), 8'd3);
      cyc(1);
      chk("alarm", 8'(bus_if.STATE), 8'd4);
      chk("alarm_siren", 8'(bus_if.SIREN_OUT), 8'd1);
      chk("alarm_latch", 8'(bus_if.ZONE_LATCH), 8'b0010);

      // Siren period 10 cycles, then SILENCED; new zone re-triggers.
      cyc(9);
      chk("alarm_last", 8'(bus_if.STATE), 8'd4);
      cyc(1);
      chk("silenced", 8'(bus_if.STATE), 8'd5);
      chk("silenced_siren", 8'(bus_if.SIREN_OUT), 8'd0);
      bus_if.SENSOR_IN = 4'b0100;
      cyc(3);
      chk("retrigger", 8'(bus_if.STATE), 8'd4);
      chk("retrigger_siren", 8'(bus_if.SIREN_OUT), 8'd1);
      chk("retrigger_latch", 8'(bus_if.ZONE_LATCH), 8'b0110);
      bus_if.SENSOR_IN = 4'b0000;
      async_reset();
      cyc(2);

      // Keypad error lockout: third error edge forces ALARM.
      press(2'd0);
      cyc(8);
      chk("rearmed", 8'(bus_if.STATE), 8'd2);
      press(2'd2); cyc(1);
      press(2'd2); cyc(1);
      chk("two_errors", 8'(bus_if.STATE), 8'd2);
      press(2'd2);
      chk("lockout", 8'(bus_if.STATE), 8'd4);
      // Held OK is a single event: disarm, no re-arm.
      bus_if.KEY_STATUS = 2'd0;
      cyc(1);
      chk("ok_disarm", 8'(bus_if.STATE), 8'd0);
      cyc(19);
      chk("ok_held", 8'(bus_if.STATE), 8'd0);
      bus_if.KEY_STATUS = 2'd3;
      cyc(1);

      // Bypassed zone is ignored and never latched.
      bus_if.ZONE_BYPASS = 4'b0001;
      press(2'd0);
      bus_if.ZONE_BYPASS = 4'b0000;
      cyc(8);
      chk("bypass_armed", 8'(bus_if.STATE), 8'd2);
      bus_if.SENSOR_IN = 4'b0001;
      cyc(5);
      chk("bypass_state", 8'(bus_if.STATE), 8'd2);
      chk("bypass_latch", 8'(bus_if.ZONE_LATCH), 8'd0);
      bus_if.SENSOR_IN = 4'b0000;
      cyc(3);

      // OK on the last entry-delay cycle wins over expiry.
      bus_if.SENSOR_IN = 4'b0010;
      cyc(3);
      chk("entry2_first", 8'(bus_if.STATE), 8'd3);
      bus_if.SENSOR_IN = 4'b0000;
      cyc(5);
      chk("entry2_last", 8'(bus_if.STATE), 8'd3);
      press(2'd0);
      chk("ok_vs_expiry", 8'(bus_if.STATE), 8'd0);
      chk("ok_vs_expiry_siren", 8'(bus_if.SIREN_OUT), 8'd0);
      cyc(2);

      // Randomized traffic.
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            r = $urandom_range(0, 19);
            if (r < 2)      bus_if.KEY_STATUS = 2'd0;
            else if (r < 6) bus_if.KEY_STATUS = 2'd2;
            else if (r < 7) bus_if.KEY_STATUS = 2'd1;
            else            bus_if.KEY_STATUS = 2'd3;
            hold = $urandom_range(1, 4);
         end
         hold--;
         r = $urandom_range(0, 15);
         if (r == 0)      bus_if.SENSOR_IN = 4'($urandom_range(0, 15));
         else if (r < 3)  bus_if.SENSOR_IN = 4'd0;
         else             bus_if.SENSOR_IN = bus_if.SENSOR_IN;
         bus_if.ZONE_BYPASS = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         if ($urandom_range(0, 399) == 0) async_reset();
         cyc(1);
      end

      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
